// File: rtl/reorder_buffer.sv
// In-order retirement buffer. Entries are allocated at the tail on dispatch and
// marked done on writeback. The head retires once it is done, which returns the
// superseded physical registers to the free lists.
module reorder_buffer #(
    parameter  int unsigned DEPTH     = 16,
    parameter  int unsigned NUM_D_REG = 32,
    parameter  int unsigned NUM_S_REG = 8,
    localparam int unsigned TAG_W     = $clog2(DEPTH),
    localparam int unsigned RW_W      = $clog2(NUM_D_REG),
    localparam int unsigned RS_W      = $clog2(NUM_S_REG),
    localparam int unsigned CNT_W     = TAG_W + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             dispatch_valid,
    input  logic             dispatch_use_rw,
    input  logic [RW_W-1:0]  dispatch_prev_rw,
    input  logic             dispatch_use_rs,
    input  logic [RS_W-1:0]  dispatch_prev_rs,
    output logic [TAG_W-1:0] dispatch_tag,
    output logic             full,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic             flush,
    output logic             commit_valid,
    output logic             return_r,
    output logic [RW_W-1:0]  r_addr,
    output logic             return_s,
    output logic [RS_W-1:0]  s_addr,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [DEPTH-1:0] use_rw_q, use_rw_d;
    logic [DEPTH-1:0] use_rs_q, use_rs_d;
    logic [RW_W-1:0]  prev_rw_q [DEPTH];
    logic [RW_W-1:0]  prev_rw_d [DEPTH];
    logic [RS_W-1:0]  prev_rs_q [DEPTH];
    logic [RS_W-1:0]  prev_rs_d [DEPTH];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic accept;
    logic retire;

    // Full blocks dispatch even when the head retires in the same cycle.
    assign full   = (count_q == CNT_W'(DEPTH));
    assign accept = dispatch_valid & ~full & ~flush;
    assign retire = valid_q[head_q] & done_q[head_q] & ~flush;

    assign dispatch_tag = tail_q;
    assign count        = count_q;
    assign commit_valid = retire;
    assign return_r     = retire & use_rw_q[head_q];
    assign return_s     = retire & use_rs_q[head_q];
    assign r_addr       = retire ? prev_rw_q[head_q] : '0;
    assign s_addr       = retire ? prev_rs_q[head_q] : '0;

    // Next-state: flush overrides writeback, retirement and allocation.
    always_comb begin
        valid_d   = valid_q;
        done_d    = done_q;
        use_rw_d  = use_rw_q;
        use_rs_d  = use_rs_q;
        prev_rw_d = prev_rw_q;
        prev_rs_d = prev_rs_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wb_valid && valid_q[wb_tag]) begin
                done_d[wb_tag] = 1'b1;
            end
            if (retire) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + TAG_W'(1);
            end
            // Tail never aliases the retiring head here: that needs a full buffer.
            if (accept) begin
                valid_d[tail_q]   = 1'b1;
                done_d[tail_q]    = 1'b0;
                use_rw_d[tail_q]  = dispatch_use_rw;
                use_rs_d[tail_q]  = dispatch_use_rs;
                prev_rw_d[tail_q] = dispatch_prev_rw;
                prev_rs_d[tail_q] = dispatch_prev_rs;
                tail_d            = tail_q + TAG_W'(1);
            end
            count_d = count_q + CNT_W'(accept) - CNT_W'(retire);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_q   <= '0;
            done_q    <= '0;
            use_rw_q  <= '0;
            use_rs_q  <= '0;
            prev_rw_q <= '{default: '0};
            prev_rs_q <= '{default: '0};
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            done_q    <= done_d;
            use_rw_q  <= use_rw_d;
            use_rs_q  <= use_rs_d;
            prev_rw_q <= prev_rw_d;
            prev_rs_q <= prev_rs_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a queue-based model is checked every cycle,
// and hand-computed literals pin the key scenarios.
module tb_reorder_buffer;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned NUM_D_REG = 32;
    localparam int unsigned NUM_S_REG = 8;
    localparam int unsigned TAG_W     = $clog2(DEPTH);
    localparam int unsigned RW_W      = $clog2(NUM_D_REG);
    localparam int unsigned RS_W      = $clog2(NUM_S_REG);
    localparam int unsigned CNT_W     = TAG_W + 1;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             dispatch_valid = 1'b0;
    logic             dispatch_use_rw = 1'b0;
    logic [RW_W-1:0]  dispatch_prev_rw = '0;
    logic             dispatch_use_rs = 1'b0;
    logic [RS_W-1:0]  dispatch_prev_rs = '0;
    logic [TAG_W-1:0] dispatch_tag;
    logic             full;
    logic             wb_valid = 1'b0;
    logic [TAG_W-1:0] wb_tag = '0;
    logic             flush = 1'b0;
    logic             commit_valid;
    logic             return_r;
    logic [RW_W-1:0]  r_addr;
    logic             return_s;
    logic [RS_W-1:0]  s_addr;
    logic [CNT_W-1:0] count;

    reorder_buffer #(.DEPTH(DEPTH), .NUM_D_REG(NUM_D_REG), .NUM_S_REG(NUM_S_REG)) dut (
        .clk(clk), .n_rst(n_rst),
        .dispatch_valid(dispatch_valid), .dispatch_use_rw(dispatch_use_rw),
        .dispatch_prev_rw(dispatch_prev_rw), .dispatch_use_rs(dispatch_use_rs),
        .dispatch_prev_rs(dispatch_prev_rs), .dispatch_tag(dispatch_tag), .full(full),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .flush(flush),
        .commit_valid(commit_valid), .return_r(return_r), .r_addr(r_addr),
        .return_s(return_s), .s_addr(s_addr), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        bit use_rw;
        int prev_rw;
        bit use_rs;
        int prev_rs;
        bit done;
    } ent_t;

    ent_t q[$];
    int   m_tail = 0;
    bit   m_acc;
    bit   m_com;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: in-order queue of live instructions, oldest first.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst || flush) begin
            q.delete();
            m_tail = 0;
        end else begin
            m_acc = dispatch_valid && (q.size() < DEPTH);
            m_com = (q.size() > 0) && q[0].done;
            if (wb_valid)
                foreach (q[i]) if (q[i].tag == int'(wb_tag)) q[i].done = 1'b1;
            if (m_com) void'(q.pop_front());
            if (m_acc) begin
                q.push_back('{tag: m_tail, use_rw: dispatch_use_rw, prev_rw: int'(dispatch_prev_rw),
                              use_rs: dispatch_use_rs, prev_rs: int'(dispatch_prev_rs), done: 1'b0});
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin : compare
        bit ec;
        ec = (q.size() > 0) && q[0].done && !flush && n_rst;
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("count", 32'(count), 32'(q.size()));
        chk("dispatch_tag", 32'(dispatch_tag), 32'(m_tail));
        chk("commit_valid", 32'(commit_valid), 32'(ec));
        chk("return_r", 32'(return_r), ec ? 32'(q[0].use_rw) : 32'd0);
        chk("r_addr", 32'(r_addr), ec ? 32'(q[0].prev_rw) : 32'd0);
        chk("return_s", 32'(return_s), ec ? 32'(q[0].use_rs) : 32'd0);
        chk("s_addr", 32'(s_addr), ec ? 32'(q[0].prev_rs) : 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        dispatch_valid = 1'b0;
        wb_valid       = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic disp(input bit urw, input int prw, input bit urs, input int prs);
        dispatch_valid   = 1'b1;
        dispatch_use_rw  = urw;
        dispatch_prev_rw = RW_W'(prw);
        dispatch_use_rs  = urs;
        dispatch_prev_rs = RS_W'(prs);
    endtask

    task automatic wb(input int t);
        wb_valid = 1'b1;
        wb_tag   = TAG_W'(t);
    endtask

    task automatic do_flush();
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_tag", 32'(dispatch_tag), 32'd0);
        chk("rst_commit", 32'(commit_valid), 32'd0);
        chk("rst_raddr", 32'(r_addr), 32'd0);
        n_rst = 1'b1;
        tick();

        // Single dispatch, writeback, commit next cycle
        disp(1, 5, 0, 0);
        tick();
        idle();
        wb(0);
        settle();
        chk("s1_no_same_cycle_commit", 32'(commit_valid), 32'd0);
        tick();
        idle();
        settle();
        chk("s1_commit", 32'(commit_valid), 32'd1);
        chk("s1_return_r", 32'(return_r), 32'd1);
        chk("s1_r_addr", 32'(r_addr), 32'd5);
        chk("s1_return_s", 32'(return_s), 32'd0);
        tick();
        chk("s1_count", 32'(count), 32'd0);

        // Fill to full, overflow dispatch ignored
        do_flush();
        for (int i = 0; i < 16; i++) begin
            disp(1, i + 1, 0, 0);
            tick();
        end
        settle();
        chk("s2_full", 32'(full), 32'd1);
        chk("s2_count", 32'(count), 32'd16);
        tick();
        idle();
        settle();
        chk("s2_count_after17", 32'(count), 32'd16);
        chk("s2_tail", 32'(dispatch_tag), 32'd0);

        // Full with head done: commit happens, dispatch rejected
        wb(0);
        tick();
        idle();
        disp(1, 20, 0, 0);
        settle();
        chk("s3_commit", 32'(commit_valid), 32'd1);
        chk("s3_r_addr", 32'(r_addr), 32'd1);
        tick();
        idle();
        settle();
        chk("s3_count", 32'(count), 32'd15);
        chk("s3_tail", 32'(dispatch_tag), 32'd0);

        // Out-of-order completion, in-order commit
        do_flush();
        for (int i = 0; i < 3; i++) begin
            disp(1, 10 + i, 0, 0);
            tick();
        end
        idle();
        wb(2);
        tick();
        wb(1);
        tick();
        idle();
        settle();
        chk("s4_no_commit", 32'(commit_valid), 32'd0);
        wb(0);
        tick();
        idle();
        settle();
        chk("s4_c0", 32'(r_addr), 32'd10);
        tick();
        chk("s4_c1", 32'(r_addr), 32'd11);
        tick();
        chk("s4_c2", 32'(r_addr), 32'd12);
        tick();
        chk("s4_empty", 32'(count), 32'd0);

        // Flush beats commit
        for (int i = 0; i < 5; i++) begin
            disp(1, i, 1, i % 8);
            tick();
        end
        idle();
        wb(3);
        tick();
        idle();
        flush = 1'b1;
        settle();
        chk("s5_flush_commit", 32'(commit_valid), 32'd0);
        chk("s5_flush_return", 32'(return_r), 32'd0);
        tick();
        flush = 1'b0;
        settle();
        chk("s5_count", 32'(count), 32'd0);
        chk("s5_tag", 32'(dispatch_tag), 32'd0);
        chk("s5_full", 32'(full), 32'd0);

        // Writeback to an empty slot is ignored
        wb(0);
        tick();
        idle();
        disp(0, 0, 0, 0);
        tick();
        idle();
        settle();
        chk("s6_stale_wb", 32'(commit_valid), 32'd0);
        // No-rename entry still retires
        wb(0);
        tick();
        idle();
        settle();
        chk("s6_commit", 32'(commit_valid), 32'd1);
        chk("s6_rr", 32'(return_r), 32'd0);
        chk("s6_rs", 32'(return_s), 32'd0);
        tick();

        // Wrap-around
        do_flush();
        for (int k = 0; k < 20; k++) begin
            disp(0, 0, 1, 3);
            tick();
            idle();
            wb(k % 16);
            tick();
            idle();
            settle();
            chk("s7_s_addr", 32'(s_addr), 32'd3);
            chk("s7_return_s", 32'(return_s), 32'd1);
            tick();
        end
        chk("s7_tag", 32'(dispatch_tag), 32'd4);

        // Asynchronous reset mid-operation
        disp(1, 7, 1, 2);
        tick();
        tick();
        idle();
        wb(4);
        tick();
        idle();
        n_rst = 1'b0;
        settle();
        chk("s8_count", 32'(count), 32'd0);
        chk("s8_commit", 32'(commit_valid), 32'd0);
        chk("s8_tag", 32'(dispatch_tag), 32'd0);
        tick();
        n_rst = 1'b1;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
